nt_subckt_monitor: RTL and testbench

NT_SUBCKT_MONITOR -- requirements
Module: nt_subckt_monitor

---
 rtl/nt_subckt_monitor.sv | 128 ++++++++++++
 tb/tb_nt_subckt_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nt_subckt_monitor.sv
// nt_subckt_monitor
//
// Per-channel monitor: a small registered boolean function over four staged
// input streams, followed by a consecutive-high counter that sets a sticky
// trigger flag once the function output has been high for THRESH sampled
// cycles in a row.
//
// Ports
//   I1470     clock, all state changes on its rising edge
//   I1477     synchronous active-high reset
//   en        advance enable; when low every register holds
//   in_a      per-channel data, routed through a DEPTH-long delay chain
//   in_b      per-channel data, staged twice (B, then M)
//   in_c      per-channel data, staged once
//   in_d      per-channel data, used unregistered by the output function
//   trig_clr  synchronous clear of counters and trigger flags
//   out       registered per-channel function result
//   trig      sticky per-channel trigger flags
//   any_trig  registered OR of the trigger flags

module nt_subckt_monitor #(
    parameter int unsigned CH     = 4,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned THRESH = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic          I1470,
    input  logic          I1477,
    input  logic          en,
    input  logic [CH-1:0] in_a,
    input  logic [CH-1:0] in_b,
    input  logic [CH-1:0] in_c,
    input  logic [CH-1:0] in_d,
    input  logic          trig_clr,
    output logic [CH-1:0] out,
    output logic [CH-1:0] trig,
    output logic          any_trig
);

    // Reject parameter sets the counter cannot represent.
    if (((1 << CNT_W) - 1) < THRESH) begin : g_bad_cnt_w
        $error("nt_subckt_monitor: CNT_W too small for THRESH");
    end
    if (CH < 1 || DEPTH < 1 || THRESH < 1) begin : g_bad_params
        $error("nt_subckt_monitor: CH, DEPTH and THRESH must be >= 1");
    end

    localparam logic [CNT_W-1:0] CntHit = CNT_W'(THRESH - 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    // a_q[k] holds in_a delayed k+1 edges; a_q[DEPTH-1] is the tap.
    logic [DEPTH-1:0][CH-1:0] a_q, a_d;
    logic [CH-1:0]            b_q, b_d;
    logic [CH-1:0]            m_q, m_d;
    logic [CH-1:0]            c_q, c_d;
    logic [CH-1:0]            out_q, out_d;
    logic [CH-1:0]            trig_q, trig_d;
    logic                     any_q, any_d;
    logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CH-1:0]            trig_set;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        c_d      = c_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        trig_d   = trig_q;
        any_d    = any_q;
        trig_set = '0;

        if (en) begin
            a_d[0] = in_a;
            for (int k = 1; k < int'(DEPTH); k++) begin
                a_d[k] = a_q[k-1];
            end
            b_d = in_b;
            m_d = b_q;
            c_d = in_c;

            // NOR(~B, tap) reduces to B & ~tap.
            out_d = (b_q & ~a_q[DEPTH-1]) | (m_q & ~(c_q | in_d));

            // Counter and trigger look at the registered out, i.e. the value
            // sampled at this edge.
            for (int i = 0; i < int'(CH); i++) begin
                trig_set[i] = out_q[i] && (cnt_q[i] == CntHit);
                if (trig_clr || !out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != CntMax) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end

            // Clear wins over a simultaneous set.
            trig_d = trig_clr ? '0 : (trig_q | trig_set);
            any_d  = |trig_d;
        end
    end

    always_ff @(posedge I1470) begin
        if (I1477) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            c_q    <= '0;
            out_q  <= '0;
            cnt_q  <= '0;
            trig_q <= '0;
            any_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            m_q    <= m_d;
            c_q    <= c_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            trig_q <= trig_d;
            any_q  <= any_d;
        end
    end

    assign out      = out_q;
    assign trig     = trig_q;
    assign any_trig = any_q;

endmodule

// File: tb/tb_nt_subckt_monitor.sv
// Scoreboard bench for nt_subckt_monitor (CH=4, DEPTH=2, THRESH=3, CNT_W=2).
// Each step computes the expected post-edge state from a history of sampled
// inputs, pushes it to a queue, clocks the DUT and pops/compares.

module tb_nt_subckt_monitor;

    localparam int unsigned CH     = 4;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned THRESH = 3;
    localparam int unsigned CNT_W  = 2;
    localparam int          HLEN   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr;
    logic [CH-1:0] a, b, c, d;
    logic [CH-1:0] out;
    logic [CH-1:0] trig;
    logic          any_trig;

    always #5 clk = ~clk;

    nt_subckt_monitor #(
        .CH    (CH),
        .DEPTH (DEPTH),
        .THRESH(THRESH),
        .CNT_W (CNT_W)
    ) dut (
        .I1470   (clk),
        .I1477   (rst),
        .en      (en),
        .in_a    (a),
        .in_b    (b),
        .in_c    (c),
        .in_d    (d),
        .trig_clr(clr),
        .out     (out),
        .trig    (trig),
        .any_trig(any_trig)
    );

    typedef struct packed {
        logic [CH-1:0]       o;
        logic [CH-1:0]       t;
        logic                an;
        logic [CH*CNT_W-1:0] cn;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // History of inputs sampled on advancing edges since reset; index 0 is
    // the most recent. Entries that predate reset read as 0.
    logic [CH-1:0] ha[HLEN];
    logic [CH-1:0] hb[HLEN];
    logic [CH-1:0] hc[HLEN];
    logic [CH-1:0] hd[HLEN];

    logic [CH-1:0] m_out;
    logic [CH-1:0] m_trig;
    logic          m_any;
    int            m_cnt[CH];

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [CH-1:0] prev;
        exp_t          e;
        if (rst) begin
            for (int k = 0; k < HLEN; k++) begin
                ha[k] = '0; hb[k] = '0; hc[k] = '0; hd[k] = '0;
            end
            m_out  = '0;
            m_trig = '0;
            m_any  = 1'b0;
            for (int i = 0; i < int'(CH); i++) m_cnt[i] = 0;
        end else if (en) begin
            prev = m_out;
            for (int k = HLEN - 1; k > 0; k--) begin
                ha[k] = ha[k-1]; hb[k] = hb[k-1]; hc[k] = hc[k-1]; hd[k] = hd[k-1];
            end
            ha[0] = a; hb[0] = b; hc[0] = c; hd[0] = d;
            // Latencies: in_b 2 (and 3 via M), in_c 2, in_d 1, in_a DEPTH+1.
            m_out = (hb[1] & ~ha[DEPTH]) | (hb[2] & ~hc[1] & ~hd[0]);
            for (int i = 0; i < int'(CH); i++) begin
                if (prev[i] && m_cnt[i] == int'(THRESH) - 1) m_trig[i] = 1'b1;
                if (clr || !prev[i]) m_cnt[i] = 0;
                else if (m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i] = m_cnt[i] + 1;
            end
            if (clr) m_trig = '0;
            m_any = |m_trig;
        end
        e.o  = m_out;
        e.t  = m_trig;
        e.an = m_any;
        for (int i = 0; i < int'(CH); i++) e.cn[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        sb_q.push_back(e);
    endtask

    // Inputs must be set before calling; returns 1 time unit after the edge.
    task automatic step();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val("out", 32'(out), 32'(e.o));
            check_val("trig", 32'(trig), 32'(e.t));
            check_val("any_trig", 32'(any_trig), 32'(e.an));
            check_val("cnt", 32'(dut.cnt_q), 32'(e.cn));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        steps(2);
        rst = 1'b0;

        // latency: in_d high masks the M term so the in_a pulse is visible
        b = 4'b0001; d = 4'b0001;
        steps(3);
        a = 4'b0001;
        step();
        a = '0;
        steps(4);
        check_val("lat_out0_high", 32'(out[0]), 32'd1);

        // trigger on channel 1, with a one-cycle low gap after two highs
        clr = 1'b1; b = '0; d = '0;
        step();
        clr = 1'b0;
        b = 4'b0010; d = 4'b0010;
        step();
        a = 4'b0010;
        step();
        a = '0;
        steps(2);
        check_val("gap_no_trig", 32'(trig[1]), 32'd0);
        steps(4);
        check_val("trig1_set", 32'(trig[1]), 32'd1);
        check_val("any_set", 32'(any_trig), 32'd1);

        // clear priority on channel 2
        b = 4'b0100; d = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            clr = (m_out[2] && m_cnt[2] == int'(THRESH) - 1 && !m_trig[2]) ? 1'b1 : 1'b0;
            step();
            if (clr) begin
                check_val("clr_wins", 32'(trig[2]), 32'd0);
                clr = 1'b0;
                steps(3);
                check_val("trig2_after_clr", 32'(trig[2]), 32'd1);
                break;
            end
        end
        clr = 1'b0;

        // hold: en low mid-count with inputs toggling
        clr = 1'b1; step(); clr = 1'b0;
        b = 4'b1000; d = 4'b1000; a = '0; c = '0;
        steps(3);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = CH'($urandom); b = CH'($urandom); c = CH'($urandom); d = CH'($urandom);
            clr = i[0];
            step();
        end
        en = 1'b1; clr = 1'b0;
        a = '0; b = 4'b1000; c = '0; d = 4'b1000;
        steps(4);
        check_val("hold_trig3", 32'(trig[3]), 32'd1);

        // reset mid-op with trig = 1010 and en low during the reset edge
        clr = 1'b1; step(); clr = 1'b0;
        b = 4'b1010; d = 4'b1010;
        steps(6);
        check_val("pre_rst_trig", 32'(trig), 32'b1010);
        rst = 1'b1; en = 1'b0;
        step();
        check_val("rst_out", 32'(out), 32'd0);
        rst = 1'b0; en = 1'b1;
        steps(3);

        // saturation on channel 0
        b = 4'b0001; d = 4'b0001;
        steps(12);
        check_val("sat_cnt0", 32'(dut.cnt_q[0]), 32'd3);

        // random mix
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 4) != 0);
            clr = ($urandom_range(0, 19) == 0);
            a = CH'($urandom); b = CH'($urandom | $urandom);
            c = CH'($urandom & $urandom); d = CH'($urandom & $urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
